// File: rtl/mdu_iterative_if.sv
// Handshake and HI/LO bus between the core and the iterative multiply/divide unit.
interface mdu_iterative_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, src_a, src_b, hi_we, lo_we, wdata,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b, hi_we, lo_we, wdata,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: magnitude shift-add multiply or
// restoring divide, one bit per cycle, followed by a single sign-correction cycle.
module mdu_iterative #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input logic            clk,
   input logic            rst_n,
   mdu_iterative_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

   state_t             state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               is_div_r;
   logic               neg_res_r;
   logic               neg_rem_r;
   logic               dbz_r;
   logic               done_r;
   logic [WIDTH-1:0]   opnd_r;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic [2*WIDTH-1:0] prod_r;

   logic               signed_s;
   logic               is_div_s;
   logic               a_neg_s;
   logic               b_neg_s;
   logic               dbz_start_s;
   logic [WIDTH-1:0]   abs_a_s;
   logic [WIDTH-1:0]   abs_b_s;
   logic [WIDTH:0]     mul_sum_s;
   logic [WIDTH:0]     rem_sh_s;
   logic [WIDTH:0]     div_diff_s;
   logic [2*WIDTH-1:0] calc_next_s;
   logic [2*WIDTH-1:0] prod_neg_s;
   logic [WIDTH-1:0]   fix_hi_s;
   logic [WIDTH-1:0]   fix_lo_s;

   // Decode a start request into operand magnitudes and result signs
   always_comb begin
      signed_s    = ~bus.op[0];
      is_div_s    = bus.op[1];
      a_neg_s     = signed_s & bus.src_a[WIDTH-1];
      b_neg_s     = signed_s & bus.src_b[WIDTH-1];
      dbz_start_s = is_div_s & (bus.src_b == {WIDTH{1'b0}});
      if (a_neg_s) abs_a_s = -bus.src_a;
      else         abs_a_s = bus.src_a;
      if (b_neg_s) abs_b_s = -bus.src_b;
      else         abs_b_s = bus.src_b;
   end

   // One iteration: prod_r holds {accumulator, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      mul_sum_s  = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){prod_r[0]}} & {1'b0, opnd_r});
      rem_sh_s   = prod_r[2*WIDTH-1:WIDTH-1];
      div_diff_s = rem_sh_s - {1'b0, opnd_r};
      if (is_div_r) begin
         if (div_diff_s[WIDTH]) calc_next_s = {prod_r[2*WIDTH-2:0], 1'b0};
         else                   calc_next_s = {div_diff_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b1};
      end else begin
         calc_next_s = {mul_sum_s, prod_r[WIDTH-1:1]};
      end
   end

   // Sign correction; divide-by-zero returns the raw dividend kept in the low half
   always_comb begin
      prod_neg_s = -prod_r;
      fix_hi_s   = prod_r[2*WIDTH-1:WIDTH];
      fix_lo_s   = prod_r[WIDTH-1:0];
      if (dbz_r) begin
         fix_hi_s = prod_r[WIDTH-1:0];
         fix_lo_s = {WIDTH{1'b1}};
      end else if (is_div_r) begin
         if (neg_res_r) fix_lo_s = -prod_r[WIDTH-1:0];
         else           fix_lo_s = prod_r[WIDTH-1:0];
         if (neg_rem_r) fix_hi_s = -prod_r[2*WIDTH-1:WIDTH];
         else           fix_hi_s = prod_r[2*WIDTH-1:WIDTH];
      end else if (neg_res_r) begin
         {fix_hi_s, fix_lo_s} = prod_neg_s;
      end else begin
         {fix_hi_s, fix_lo_s} = prod_r;
      end
   end

   // Control FSM, operand capture, iteration and HI/LO update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         is_div_r  <= 1'b0;
         neg_res_r <= 1'b0;
         neg_rem_r <= 1'b0;
         dbz_r     <= 1'b0;
         done_r    <= 1'b0;
         opnd_r    <= {WIDTH{1'b0}};
         hi_r      <= {WIDTH{1'b0}};
         lo_r      <= {WIDTH{1'b0}};
         prod_r    <= {(2*WIDTH){1'b0}};
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.hi_we) hi_r <= bus.wdata;
               if (bus.lo_we) lo_r <= bus.wdata;
               if (bus.start) begin
                  is_div_r  <= is_div_s;
                  neg_res_r <= a_neg_s ^ b_neg_s;
                  neg_rem_r <= a_neg_s;
                  dbz_r     <= dbz_start_s;
                  cnt_r     <= CNT_W'(WIDTH);
                  opnd_r    <= abs_b_s;
                  if (dbz_start_s) begin
                     prod_r  <= {{WIDTH{1'b0}}, bus.src_a};
                     state_r <= FIX;
                  end else begin
                     prod_r  <= {{WIDTH{1'b0}}, abs_a_s};
                     state_r <= CALC;
                  end
               end
            end
            CALC: begin
               prod_r <= calc_next_s;
               cnt_r  <= cnt_r - CNT_W'(1);
               if (cnt_r == CNT_W'(1)) state_r <= FIX;
            end
            FIX: begin
               hi_r    <= fix_hi_s;
               lo_r    <= fix_lo_s;
               done_r  <= 1'b1;
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = (state_r != IDLE);
   assign bus.done        = done_r;
   assign bus.div_by_zero = dbz_r;
   assign bus.hi          = hi_r;
   assign bus.lo          = lo_r;
endmodule
